// File: rtl/gpr_2r1w.sv
// gpr_2r1w: 2-read/1-write register file with r0 hardwired to zero and a per-register busy scoreboard.
// Latency: reads combinational; write and busy updates land on the rising edge (optional write-through via GPR_WRITE_BYPASS_EN).
// Backpressure: none; every write, reserve and read is accepted every cycle.
module gpr_2r1w #(
    parameter  int N    = 32,
    parameter  int Nreg = 32,
    localparam int K    = $clog2(Nreg)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [K-1:0] addr_a,
    input  logic [K-1:0] addr_b,
    output logic [N-1:0] q_a,
    output logic [N-1:0] q_b,
    output logic         busy_a,
    output logic         busy_b,
    input  logic         wren,
    input  logic [K-1:0] waddr,
    input  logic [N-1:0] d,
    input  logic         rsv_en,
    input  logic [K-1:0] rsv_addr
);

    logic [N-1:0]    regs [Nreg];
    logic [Nreg-1:0] busy;

    logic wr_ok;
    logic rsv_ok;

    assign wr_ok  = wren && (waddr != '0);
    assign rsv_ok = rsv_en && (rsv_addr != '0);

    // Reserve is assigned after the write-clear so a same-address reserve
    // wins: the newer producer has already issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Nreg; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_ok) begin
                regs[waddr] <= d;
                busy[waddr] <= 1'b0;
            end
            if (rsv_ok) begin
                busy[rsv_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        q_a = regs[addr_a];
        q_b = regs[addr_b];
`ifdef GPR_WRITE_BYPASS_EN
        if (wr_ok && (waddr == addr_a)) q_a = d;
        if (wr_ok && (waddr == addr_b)) q_b = d;
`endif
        if (addr_a == '0) q_a = '0;
        if (addr_b == '0) q_b = '0;
    end

    // Busy is deliberately not forwarded; the issue stage sees edge-aligned state.
    assign busy_a = busy[addr_a] && (addr_a != '0);
    assign busy_b = busy[addr_b] && (addr_b != '0);

endmodule

// File: tb/tb_gpr_2r1w.sv
// Directed bench for gpr_2r1w: table-driven read vectors plus hand sequences for bypass, scoreboard and reset corners.
module tb_gpr_2r1w;
    localparam int N    = 32;
    localparam int NREG = 32;
    localparam int K    = 5;

`ifdef GPR_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [K-1:0] addr_a, addr_b, waddr, rsv_addr;
    logic [N-1:0] q_a, q_b, d;
    logic         busy_a, busy_b, wren, rsv_en;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [K-1:0] aa;
        logic [K-1:0] ab;
        logic [N-1:0] qa;
        logic [N-1:0] qb;
        logic         ba;
        logic         bb;
    } vec_t;

    vec_t vecs [6];

    gpr_2r1w #(.N(N), .Nreg(NREG)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .q_a     (q_a),
        .q_b     (q_b),
        .busy_a  (busy_a),
        .busy_b  (busy_b),
        .wren    (wren),
        .waddr   (waddr),
        .d       (d),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic rd(input logic [K-1:0] aa, input logic [K-1:0] ab);
        addr_a = aa;
        addr_b = ab;
        #1;
    endtask

    task automatic wr(input logic [K-1:0] a, input logic [N-1:0] v);
        wren  = 1'b1;
        waddr = a;
        d     = v;
        step();
        wren  = 1'b0;
    endtask

    task automatic scan_zero(input string nm);
        for (int a = 0; a < NREG; a++) begin
            rd(K'(a), K'(NREG - 1 - a));
            chk({nm, "_q_a"}, q_a, '0);
            chk({nm, "_q_b"}, q_b, '0);
            chk({nm, "_busy_a"}, {31'b0, busy_a}, '0);
            chk({nm, "_busy_b"}, {31'b0, busy_b}, '0);
        end
    endtask

    initial begin
        rst = 1'b1; wren = 1'b0; rsv_en = 1'b0;
        addr_a = '0; addr_b = '0; waddr = '0; rsv_addr = '0; d = '0;

        vecs[0] = '{5'd5,  5'd10, 32'hDEADBEEF, 32'hCAFEBABE, 1'b0, 1'b0};
        vecs[1] = '{5'd31, 5'd31, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
        vecs[2] = '{5'd0,  5'd31, 32'h00000000, 32'h12345678, 1'b0, 1'b0};
        vecs[3] = '{5'd3,  5'd5,  32'h00000000, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[4] = '{5'd10, 5'd3,  32'hCAFEBABE, 32'h00000000, 1'b0, 1'b1};
        vecs[5] = '{5'd7,  5'd0,  32'h00000000, 32'h00000000, 1'b0, 1'b0};

        // Power-on reset
        step(); step();
        rst = 1'b0;
        rd(5'd5, 5'd10);
        chk("por_q_a", q_a, '0);
        chk("por_q_b", q_b, '0);
        chk("por_busy_a", {31'b0, busy_a}, '0);

        // Writes, then a disabled write that must not land
        wr(5'd5, 32'hDEADBEEF);
        wr(5'd10, 32'hCAFEBABE);
        wr(5'd31, 32'h12345678);
        waddr = 5'd5; d = 32'hAAAAAAAA;
        step();

        // Register 0: write and reserve both discarded
        wren = 1'b1; waddr = '0; d = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_addr = '0;
        rd(5'd0, 5'd0);
        chk("r0_q_during_write", q_a, '0);
        step();
        wren = 1'b0; rsv_en = 1'b0;
        rd(5'd0, 5'd0);
        chk("r0_q_after", q_a, '0);
        chk("r0_busy_after", {31'b0, busy_a}, '0);

        // Reserve 3: busy only after the edge
        rsv_en = 1'b1; rsv_addr = 5'd3;
        rd(5'd3, 5'd3);
        chk("rsv3_busy_before_edge", {31'b0, busy_a}, '0);
        step();
        rsv_en = 1'b0;
        rd(5'd3, 5'd3);
        chk("rsv3_busy_after_edge", {31'b0, busy_a}, 32'd1);

        foreach (vecs[i]) begin
            step();
            rd(vecs[i].aa, vecs[i].ab);
            chk($sformatf("vec%0d_q_a", i), q_a, vecs[i].qa);
            chk($sformatf("vec%0d_q_b", i), q_b, vecs[i].qb);
            chk($sformatf("vec%0d_busy_a", i), {31'b0, busy_a}, {31'b0, vecs[i].ba});
            chk($sformatf("vec%0d_busy_b", i), {31'b0, busy_b}, {31'b0, vecs[i].bb});
        end

        // Same-cycle view of a write to 7
        wren = 1'b1; waddr = 5'd7; d = 32'h0BADF00D;
        rd(5'd7, 5'd7);
        chk("bypass_q_a_before_edge", q_a, BYP ? 32'h0BADF00D : 32'h0);
        chk("bypass_q_b_before_edge", q_b, BYP ? 32'h0BADF00D : 32'h0);
        step();
        wren = 1'b0;
        rd(5'd7, 5'd7);
        chk("bypass_q_a_after_edge", q_a, 32'h0BADF00D);

        // Write clears busy on 3; busy is never forwarded
        wren = 1'b1; waddr = 5'd3; d = 32'h11111111;
        rd(5'd3, 5'd0);
        chk("wr3_busy_before_edge", {31'b0, busy_a}, 32'd1);
        step();
        wren = 1'b0;
        rd(5'd3, 5'd0);
        chk("wr3_q", q_a, 32'h11111111);
        chk("wr3_busy_cleared", {31'b0, busy_a}, '0);

        // Same-cycle write and reserve to 3: data lands, reserve wins
        wren = 1'b1; waddr = 5'd3; d = 32'h22222222; rsv_en = 1'b1; rsv_addr = 5'd3;
        step();
        wren = 1'b0; rsv_en = 1'b0;
        rd(5'd3, 5'd3);
        chk("wr_rsv_same_q", q_a, 32'h22222222);
        chk("wr_rsv_same_busy", {31'b0, busy_a}, 32'd1);

        // Clear 3, then write 4 while reserving 3
        wr(5'd3, 32'h33333333);
        wren = 1'b1; waddr = 5'd4; d = 32'h44444444; rsv_en = 1'b1; rsv_addr = 5'd3;
        step();
        wren = 1'b0; rsv_en = 1'b0;
        rd(5'd3, 5'd4);
        chk("split_busy3", {31'b0, busy_a}, 32'd1);
        chk("split_busy4", {31'b0, busy_b}, '0);
        chk("split_q4", q_b, 32'h44444444);
        chk("split_q3_stale", q_a, 32'h33333333);

        // Double reserve stays busy; a single write clears it
        rsv_en = 1'b1; rsv_addr = 5'd3;
        step();
        rsv_en = 1'b0;
        rd(5'd3, 5'd3);
        chk("dbl_rsv_busy", {31'b0, busy_a}, 32'd1);
        wr(5'd3, 32'h55555555);
        rd(5'd3, 5'd3);
        chk("dbl_rsv_cleared", {31'b0, busy_b}, '0);

        // Reset coincident with write + reserve of 9
        rst = 1'b1; wren = 1'b1; waddr = 5'd9; d = 32'h12345678; rsv_en = 1'b1; rsv_addr = 5'd9;
        step();
        rst = 1'b0; wren = 1'b0; rsv_en = 1'b0;
        rd(5'd9, 5'd5);
        chk("midrst_q9", q_a, '0);
        chk("midrst_busy9", {31'b0, busy_a}, '0);
        chk("midrst_q5", q_b, '0);

        // Arbitrary state, then a two-cycle reset and a full scan
        wr(5'd12, 32'hA5A5A5A5);
        rsv_en = 1'b1; rsv_addr = 5'd20;
        wr(5'd21, 32'h5A5A5A5A);
        rsv_en = 1'b0;
        rd(5'd12, 5'd20);
        chk("pre_rst_q12", q_a, 32'hA5A5A5A5);
        chk("pre_rst_busy20", {31'b0, busy_b}, 32'd1);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        scan_zero("scan");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gpr_2r1w.md
# gpr_2r1w

Parametrised general-purpose register file for the pipelined multi-core MIPS datapath, replacing the single-port `gpr`. It has two asynchronous read ports for rs/rt operand fetch and one synchronous write port for writeback. Register 0 is hardwired to zero. A per-register busy scoreboard lets the issue stage detect operands whose producing instruction has not yet written back.

## Interface
- `N`, 32: data width in bits.
- `Nreg`, 32: number of registers; power of two, ≥ 2.
- `K`, `$clog2(Nreg)`: address width; derived, not overridden.

- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `addr_a`  input  K  read port A address (rs).
- `addr_b`  input  K  read port B address (rt).
- `q_a`  output  N  read port A data.
- `q_b`  output  N  read port B data.
- `busy_a`  output  1  scoreboard bit of `addr_a`.
- `busy_b`  output  1  scoreboard bit of `addr_b`.
- `wren`  input  1  write enable.
- `waddr`  input  K  write address.
- `d`  input  N  write data.
- `rsv_en`  input  1  reserve request, issued when an instruction with a destination issues.
- `rsv_addr`  input  K  destination register to mark busy.

## Operation
- Storage: `Nreg` × `N` register array plus an `Nreg`-bit busy vector.
- Reset at a posedge with `rst`=1:
  - All registers cleared to 0 and all busy bits cleared.
  - `wren` and `rsv_en` are ignored in that cycle.
  - Outputs then read 0 for both `q_a`/`q_b` and both `busy_a`/`busy_b`.
- Write: at a posedge with `wren`=1 and `rst`=0, `reg[waddr]` ← `d` and `busy[waddr]` ← 0.
- Reserve: at a posedge with `rsv_en`=1 and `rst`=0, `busy[rsv_addr]` ← 1.
- Write and reserve to the same address in the same cycle: the data is written, and the busy bit ends at 1 (reserve wins, because a newer producer has issued).
- Write and reserve to different addresses: both take effect independently.
- Register 0:
  - Writes are discarded and reserves are discarded.
  - `q_x` is always 0 and `busy_x` is always 0 when `addr_x`=0, including under bypass.
- Reads are purely combinational from `addr_a`/`addr_b`, current state, and (with the bypass compiled in) the write port.
- Both read ports may name the same register; they return identical values.
- A read of a busy register still returns the stored (stale) data; interpreting `busy` is the consumer's job.
- The scoreboard is single-outstanding per register. A second reserve of an already-busy register leaves it busy, and the first write clears it.

## Timing
- Write latency: data is visible on `q_a`/`q_b` after the posedge that performs the write. The same-cycle view depends on the configuration below.
- Busy latency: the bit sets or clears on the posedge of the reserve or write. It is never bypassed combinationally.
- Read path: zero cycles, combinational from the address inputs.
- No handshakes and no stalls: every request is accepted every cycle.
- Reset mid-operation: a reset coincident with `wren`/`rsv_en` discards them. State is all-zero from the next cycle onward.

## Configuration
- Macro: `GPR_WRITE_BYPASS_EN`.
- Defined: write-through forwarding. If `wren`=1, `waddr`≠0 and `waddr`==`addr_x`, then `q_x` = `d` in the same cycle, before the edge. This resolves the writeback/decode hazard in the same cycle. `busy_x` is not bypassed.
- Undefined: `q_x` always reflects stored state. The pipeline must then forward or stall for one extra cycle.

## Test plan
- Reset: hold `rst` for 2 cycles after arbitrary writes and reserves → every address reads `q`=0 and `busy`=0 on both ports.
- Write/read: write 5←DEADBEEF, 10←CAFEBABE, 31←12345678. Then set `addr_a`=5 and `addr_b`=10 → DEADBEEF / CAFEBABE. Set `addr_a`=`addr_b`=31 → 12345678 on both. A cycle with `wren`=0, `d`=AAAAAAAA, `waddr`=5 leaves reg 5 at DEADBEEF.
- Zero register: write 0←FFFFFFFF with `rsv_en`, `rsv_addr`=0 → `q_a`=0 and `busy_a`=0 with `addr_a`=0, in both configurations.
- Bypass: in the cycle writing 7←0BADF00D with `addr_a`=7:
  - With `GPR_WRITE_BYPASS_EN`: `q_a`=0BADF00D before the edge.
  - Without it: `q_a` shows the old value until after the edge.
- Scoreboard:
  - Reserve 3 → `busy_a`=1 at `addr_a`=3 from the next cycle.
  - Write 3←11111111 → `busy_a`=0 after the edge.
  - Same-cycle write 3←22222222 with reserve 3 → reg 3 = 22222222 and `busy`=1.
  - Write 4 with reserve 3 → only reg 3 is busy.
- Reset mid-operation: assert `rst` in the same cycle as a write 9←12345678 and reserve 9 → reg 9 reads 0 and `busy` reads 0 afterward.
